// File: rtl/nrs_cinit_sched_rx_if.sv
// Handshake and payload bundle between the RX NRS scheduler and its environment.
interface nrs_cinit_sched_rx_if #(
  parameter int unsigned CINIT_W = 31,
  parameter int unsigned CELL_W  = 9
);
  logic               frame_start;
  logic [CELL_W-1:0]  ncell_id;
  logic               frame_even;
  logic               gold_done;
  logic [CINIT_W-1:0] cinit;
  logic               gold_start;
  logic               cinit_run;
  logic [4:0]         slot_num;
  logic               l_sym;
  logic               busy;
  logic               frame_done;

  modport master (
    output frame_start, ncell_id, frame_even, gold_done,
    input  cinit, gold_start, cinit_run, slot_num, l_sym, busy, frame_done
  );

  modport slave (
    input  frame_start, ncell_id, frame_even, gold_done,
    output cinit, gold_start, cinit_run, slot_num, l_sym, busy, frame_done
  );
endinterface

// File: rtl/nrs_cinit_sched_rx.sv
// Per-frame RX NRS c_init scheduler: walks slot/symbol pairs, multiplies out c_init, drives the Gold generator.
// Optional NSSS_SKIP_EN: on even frames also skip subframe 9 (slots 18,19).
module nrs_cinit_sched_rx #(
  parameter int unsigned CINIT_W = 31,
  parameter int unsigned CELL_W  = 9
) (
  input logic                  clk,
  input logic                  rst,
  nrs_cinit_sched_rx_if.slave  bus
);

  localparam int unsigned A_W    = 8;
  localparam int unsigned B_W    = CELL_W + 1;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, CALC, START, WAIT, NEXT} state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [ACC_W-1:0]    acc_q, acc_n;
  logic [CELL_W-1:0]   ncell_q, ncell_n;
  logic                even_q, even_n;
  logic [SLOT_W-1:0]   slot_q, slot_n;
  logic                l_q, l_n;
  logic [CINIT_W-1:0]  cinit_q, cinit_n;
  logic                gs_q, gs_n;
  logic                cr_q, cr_n;
  logic                busy_q, busy_n;
  logic                fd_q, fd_n;

  logic [A_W-1:0]      a_op;
  logic [B_W-1:0]      b_op;
  logic [ACC_W-1:0]    partial;
  logic [ACC_W-1:0]    acc_sum;
  logic                last_pair;

  // Multiplier operands: a = 7*(ns+1) + l + 1 with l in {5,6}, b = 2N+1
  assign a_op    = A_W'(slot_q) * A_W'(7) + A_W'(13) + A_W'(l_q);
  assign b_op    = B_W'({ncell_q, 1'b1});
  assign partial = a_op[cnt_q] ? (ACC_W'(b_op) << cnt_q) : '0;
  assign acc_sum = ((cnt_q == '0) ? '0 : acc_q) + partial;

`ifdef NSSS_SKIP_EN
  assign last_pair = l_q && ((slot_q == SLOT_W'(19)) || (even_q && (slot_q == SLOT_W'(17))));
`else
  logic unused_even;
  assign unused_even = even_q;
  assign last_pair   = l_q && (slot_q == SLOT_W'(19));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ncell_q <= '0;
      even_q  <= 1'b0;
      slot_q  <= '0;
      l_q     <= 1'b0;
      cinit_q <= '0;
      gs_q    <= 1'b0;
      cr_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      acc_q   <= acc_n;
      ncell_q <= ncell_n;
      even_q  <= even_n;
      slot_q  <= slot_n;
      l_q     <= l_n;
      cinit_q <= cinit_n;
      gs_q    <= gs_n;
      cr_q    <= cr_n;
      busy_q  <= busy_n;
      fd_q    <= fd_n;
    end
  end

  // Next-state and next-output logic; pulses default low
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    acc_n   = acc_q;
    ncell_n = ncell_q;
    even_n  = even_q;
    slot_n  = slot_q;
    l_n     = l_q;
    cinit_n = cinit_q;
    gs_n    = 1'b0;
    cr_n    = 1'b0;
    busy_n  = busy_q;
    fd_n    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          ncell_n = bus.ncell_id;
          even_n  = bus.frame_even;
          slot_n  = '0;
          l_n     = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        acc_n = acc_sum;
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          cinit_n = CINIT_W'({acc_sum, 10'd0}) + CINIT_W'(b_op);
          gs_n    = 1'b1;
          cr_n    = 1'b1;
          state_n = START;
        end
      end
      START: state_n = WAIT;
      WAIT: begin
        if (bus.gold_done) state_n = NEXT;
      end
      NEXT: begin
        cnt_n = '0;
        if (last_pair) begin
          slot_n  = '0;
          l_n     = 1'b0;
          busy_n  = 1'b0;
          fd_n    = 1'b1;
          state_n = IDLE;
        end else begin
          if (!l_q) begin
            l_n = 1'b1;
          end else begin
            l_n    = 1'b0;
            slot_n = (slot_q == SLOT_W'(9)) ? SLOT_W'(12) : slot_q + SLOT_W'(1);
          end
          state_n = CALC;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cinit      = cinit_q;
  assign bus.gold_start = gs_q;
  assign bus.cinit_run  = cr_q;
  assign bus.slot_num   = slot_q;
  assign bus.l_sym      = l_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_nrs_cinit_sched_rx.sv
// Directed self-checking bench for nrs_cinit_sched_rx.
module tb_nrs_cinit_sched_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  nrs_cinit_sched_rx_if #(.CINIT_W(31), .CELL_W(9)) bus ();

  nrs_cinit_sched_rx #(.CINIT_W(31), .CELL_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int unsigned model_cinit(input int s, input int l, input int n);
    return int'((7 * (s + 1) + l + 6) * 1024 * (2 * n + 1) + 2 * n + 1);
  endfunction

  task automatic test_reset();
    bus.frame_start = 1'b0;
    bus.ncell_id    = '0;
    bus.frame_even  = 1'b0;
    bus.gold_done   = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.cinit, bus.gold_start, bus.cinit_run, bus.slot_num, bus.l_sym, bus.busy, bus.frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got cinit=%0d gs=%b busy=%b fd=%b want all 0",
               bus.cinit, bus.gold_start, bus.busy, bus.frame_done);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.gold_start, bus.busy, bus.frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got gs=%b busy=%b fd=%b want 0 0 0",
               bus.gold_start, bus.busy, bus.frame_done);
    end
  endtask

  // Full frame with immediate acks; checks every run against the bench's own pair walk
  task automatic test_frame(input int n, input bit even, input int exp_runs,
                            input int unsigned exp_first, input int unsigned exp_second,
                            input int unsigned exp_last);
    int          runs = 0, fd_cnt = 0, first_c = -1, stray = 0;
    int          es = 0, el = 0;
    int unsigned c1 = 0, c2 = 0, cl = 0;
    bit          prev_gs = 1'b0, fin = 1'b0;
    bus.ncell_id   = 9'(n);
    bus.frame_even = even;
    @(negedge clk);
    bus.frame_start = 1'b1;
    for (int c = 0; c < 2000 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) bus.frame_start = 1'b0;
      bus.gold_done = prev_gs;
      prev_gs = bus.gold_start;
      if (bus.gold_start) begin
        if (first_c < 0) first_c = c;
        total++;
        if (bus.slot_num !== 5'(es) || bus.l_sym !== 1'(el) || bus.cinit !== 31'(model_cinit(es, el, n))) begin
          bad++;
          $display("FAIL run_pair n=%0d run=%0d: got slot=%0d l=%0d cinit=%0d want slot=%0d l=%0d cinit=%0d",
                   n, runs, bus.slot_num, bus.l_sym, bus.cinit, es, el, model_cinit(es, el, n));
        end
        total++;
        if (bus.cinit_run !== 1'b1 || bus.busy !== 1'b1 || bus.slot_num == 5'd10 || bus.slot_num == 5'd11) begin
          bad++;
          $display("FAIL run_flags n=%0d run=%0d: got cinit_run=%b busy=%b slot=%0d want 1 1 not10/11",
                   n, runs, bus.cinit_run, bus.busy, bus.slot_num);
        end
        if (runs == 0) c1 = bus.cinit;
        if (runs == 1) c2 = bus.cinit;
        cl = bus.cinit;
        runs++;
        if (el == 0) el = 1;
        else begin
          el = 0;
          es = (es == 9) ? 12 : es + 1;
        end
      end
      if (bus.frame_done) begin
        fd_cnt++;
        fin = 1'b1;
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done n=%0d: got %b want 0", n, bus.busy);
        end
      end
    end
    bus.gold_done = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL frame_timeout n=%0d: got no frame_done want frame_done", n);
    end
    total++;
    if (first_c != 8) begin
      bad++;
      $display("FAIL first_latency n=%0d: got %0d want 9", n, first_c + 1);
    end
    total++;
    if (runs != exp_runs) begin
      bad++;
      $display("FAIL run_count n=%0d even=%0d: got %0d want %0d", n, even, runs, exp_runs);
    end
    total++;
    if (c1 != exp_first || c2 != exp_second || cl != exp_last) begin
      bad++;
      $display("FAIL cinit_values n=%0d: got %0d %0d %0d want %0d %0d %0d",
               n, c1, c2, cl, exp_first, exp_second, exp_last);
    end
    repeat (6) begin
      @(negedge clk);
      if (bus.gold_start || bus.frame_done) stray++;
    end
    total++;
    if (fd_cnt != 1 || stray != 0) begin
      bad++;
      $display("FAIL frame_done_once n=%0d: got done=%0d stray=%0d want 1 0", n, fd_cnt, stray);
    end
  endtask

  // Stalled WAIT, frame_start during WAIT, gold_done during CALC
  task automatic test_handshake();
    int          lat = -1, gs_cnt = 0, state_bad = 0, busy_bad = 0;
    int unsigned hold;
    bit          seen = 1'b0;
    bus.ncell_id   = 9'd5;
    bus.frame_even = 1'b0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.gold_start) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL hs_first_start: got none want gold_start");
    end
    hold = bus.cinit;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.frame_start = (i == 10);
      if (bus.gold_start) gs_cnt++;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.slot_num !== 5'd0 || bus.l_sym !== 1'b0 || bus.cinit !== 31'(hold)) state_bad++;
    end
    bus.frame_start = 1'b0;
    total++;
    if (gs_cnt != 0 || busy_bad != 0 || state_bad != 0) begin
      bad++;
      $display("FAIL hs_stall: got gs=%0d busy_bad=%0d state_bad=%0d want 0 0 0", gs_cnt, busy_bad, state_bad);
    end
    @(negedge clk);
    bus.gold_done = 1'b1;
    for (int k = 1; k < 30 && lat < 0; k++) begin
      @(negedge clk);
      bus.gold_done = (k >= 2 && k <= 4);
      if (bus.gold_start) lat = k;
    end
    bus.gold_done = 1'b0;
    total++;
    if (lat != 10) begin
      bad++;
      $display("FAIL hs_resume_latency: got %0d want 10", lat);
    end
    total++;
    if (bus.slot_num !== 5'd0 || bus.l_sym !== 1'b1 || bus.cinit !== 31'(model_cinit(0, 1, 5))) begin
      bad++;
      $display("FAIL hs_second_run: got slot=%0d l=%0d cinit=%0d want 0 1 %0d",
               bus.slot_num, bus.l_sym, bus.cinit, model_cinit(0, 1, 5));
    end
    gs_cnt = 0;
    state_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gold_start) gs_cnt++;
      if (bus.l_sym !== 1'b1 || bus.slot_num !== 5'd0) state_bad++;
    end
    total++;
    if (gs_cnt != 0 || state_bad != 0) begin
      bad++;
      $display("FAIL hs_calc_done_ignored: got gs=%0d state_bad=%0d want 0 0", gs_cnt, state_bad);
    end
  endtask

  // Continue the stalled frame to slot 6, then reset while waiting
  task automatic test_reset_mid();
    bit prev_gs = 1'b1, hit = 1'b0;
    int fd_cnt = 0, busy_cnt = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      bus.gold_done = prev_gs;
      prev_gs = bus.gold_start;
      if (bus.gold_start && bus.slot_num == 5'd6) hit = 1'b1;
    end
    bus.gold_done = 1'b0;
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rm_reach_slot6: got none want gold_start at slot 6");
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.cinit, bus.gold_start, bus.cinit_run, bus.slot_num, bus.l_sym, bus.busy, bus.frame_done} !== '0) begin
      bad++;
      $display("FAIL rm_outputs: got cinit=%0d slot=%0d l=%b busy=%b want all 0",
               bus.cinit, bus.slot_num, bus.l_sym, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_done) fd_cnt++;
      if (bus.busy) busy_cnt++;
    end
    total++;
    if (fd_cnt != 0 || busy_cnt != 0) begin
      bad++;
      $display("FAIL rm_no_done: got fd=%0d busy=%0d want 0 0", fd_cnt, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 1'b0, 36, 13313, 14337, 150529);
    test_frame(503, 1'b0, 36, 13406191, 14437359, 151582703);
    test_handshake();
    test_reset_mid();
    test_frame(0, 1'b0, 36, 13313, 14337, 150529);
`ifdef NSSS_SKIP_EN
    test_frame(0, 1'b1, 32, 13313, 14337, 136193);
    test_frame(503, 1'b1, 32, 13406191, 14437359, 137146351);
`else
    test_frame(0, 1'b1, 36, 13313, 14337, 150529);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
